// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a load/store requester. A single access is outstanding at a time. An
// access that sees no mem_ready for TIMEOUT_CYCLES busy cycles is aborted:
// it acks with zero data and sets the sticky err flag.
//
// Build option: define MEM_ARB_RR_EN to grant simultaneous requests
// round-robin. Without it, data always wins over fetch.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; requests are sampled for a grant
// BUSY_F | fetch access on the memory port, waiting for mem_ready
// BUSY_D | load/store access on the memory port, waiting for mem_ready

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_data,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,

  output logic        stall,
  output logic        err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The count holds the number of stalled busy cycles already completed, so
  // the abort fires in the cycle where the current one is the last allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic             busy;
  logic             timeout_hit;
  logic             done;
  logic             grant_d;
  logic             grant_f;

  assign busy        = (state == BUSY_F) || (state == BUSY_D);
  // mem_ready takes precedence over an abort landing in the same cycle.
  assign timeout_hit = busy && !mem_ready && (busy_cnt == CNT_LAST);
  assign done        = busy && (mem_ready || timeout_hit);

`ifdef MEM_ARB_RR_EN
  // Set when fetch should win the next tie, i.e. data was granted last.
  logic favour_fetch;
  assign grant_d = d_req && !(f_req && favour_fetch);
`else
  assign grant_d = d_req;
`endif
  assign grant_f = f_req && !grant_d;

  // Completion handshake is combinational so the requester sees it in the
  // same cycle memory answers; data is forced to zero on an abort.
  assign f_ack   = (state == BUSY_F) && done;
  assign d_ack   = (state == BUSY_D) && done;
  assign f_data  = ((state == BUSY_F) && mem_ready) ? mem_rdata : '0;
  assign d_rdata = ((state == BUSY_D) && mem_ready) ? mem_rdata : '0;

  // Stall the pipeline while any request is waiting for its ack.
  assign stall = (f_req && !f_ack) || (d_req && !d_ack);

  // Arbitration FSM with registered memory-port outputs, timeout counter and err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy_cnt  <= '0;
      err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      favour_fetch <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          busy_cnt <= '0;
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_f) begin
            state    <= BUSY_F;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= f_addr;
          end
`ifdef MEM_ARB_RR_EN
          if (grant_d) begin
            favour_fetch <= 1'b1;
          end else if (grant_f) begin
            favour_fetch <= 1'b0;
          end
`endif
        end
        BUSY_F, BUSY_D: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (timeout_hit) begin
              err <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. The bench plays the memory: for each
// access it picks how many busy cycles pass before mem_ready, and a
// transaction-level model predicts the winner, ack cycle, data and err.
// Build with or without MEM_ARB_RR_EN; expectations follow the same macro.

module tb_mem_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_data;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        err;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_data    (f_data),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pending requests and the two pieces of history the
  // arbitration rules depend on.
  bit          f_pend, d_pend;
  logic [31:0] fa, da, dw;
  logic        dwe;
  bit          favour_fetch;
  bit          err_exp;

  task automatic add_fetch(input logic [31:0] a);
    f_pend = 1'b1;
    fa     = a;
  endtask

  task automatic add_data(input logic we, input logic [31:0] a, input logic [31:0] w);
    d_pend = 1'b1;
    dwe    = we;
    da     = a;
    dw     = w;
  endtask

  task automatic apply_reset;
    reset     = 1'b1;
    f_req     = 1'b0;
    d_req     = 1'b0;
    f_addr    = '0;
    d_addr    = '0;
    d_we      = 1'b0;
    d_wdata   = '0;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    f_pend = 0; d_pend = 0; favour_fetch = 0; err_exp = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_f_ack", f_ack, 0);
    check_eq("rst_d_ack", d_ack, 0);
    check_eq("rst_f_data", f_data, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_stall", stall, 0);
    mem_ready = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
  endtask

  // Runs one access starting in an IDLE cycle. lat = busy cycle on which
  // mem_ready rises (lat > T means memory never answers). drop_at = busy
  // cycle on which the winner lets go of its request early (0 = never).
  task automatic run_txn(input int lat, input int drop_at, input logic [31:0] rd_ack,
                         output bit got_d);
    bit          win_d;
    bit          ack_cyc, fa_exp, da_exp;
    int          e;
    logic [31:0] rd;
    f_req     = f_pend;
    f_addr    = fa;
    d_req     = d_pend;
    d_addr    = da;
    d_we      = dwe;
    d_wdata   = dw;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check_eq("idle_mem_req", mem_req, 0);
    check_eq("idle_f_ack", f_ack, 0);
    check_eq("idle_d_ack", d_ack, 0);
    check_eq("idle_stall", stall, f_pend | d_pend);
`ifdef MEM_ARB_RR_EN
    win_d = d_pend && !(f_pend && favour_fetch);
`else
    win_d = d_pend;
`endif
    e     = (lat < T) ? lat : T;
    got_d = 1'b0;
    for (int k = 1; k <= e; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        if (win_d) d_req = 1'b0;
        else f_req = 1'b0;
      end
      ack_cyc   = (k == e);
      rd        = ack_cyc ? rd_ack : $urandom;
      mem_ready = (k == lat);
      mem_rdata = rd;
      #1;
      fa_exp = ack_cyc && !win_d;
      da_exp = ack_cyc && win_d;
      check_eq("busy_mem_req", mem_req, 1);
      check_eq("busy_mem_we", mem_we, win_d ? dwe : 1'b0);
      check_eq("busy_mem_addr", mem_addr, win_d ? da : fa);
      if (win_d) check_eq("busy_mem_wdata", mem_wdata, dw);
      check_eq("f_ack", f_ack, fa_exp);
      check_eq("d_ack", d_ack, da_exp);
      check_eq("f_data", f_data, (fa_exp && lat <= T) ? rd : 32'h0);
      check_eq("d_rdata", d_rdata, (da_exp && lat <= T) ? rd : 32'h0);
      check_eq("busy_stall", stall, (f_req & ~fa_exp) | (d_req & ~da_exp));
      check_eq("busy_err", err, err_exp);
      if (ack_cyc) got_d = d_ack;
    end
    if (lat > T) err_exp = 1'b1;
    favour_fetch = win_d;
    if (win_d) d_pend = 1'b0;
    else f_pend = 1'b0;
    @(negedge clk);
    f_req     = f_pend;
    d_req     = d_pend;
    mem_ready = 1'b0;
    #1;
    check_eq("post_err", err, err_exp);
    check_eq("post_mem_req", mem_req, 0);
    check_eq("post_stall", stall, f_pend | d_pend);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gd;
    bit exp_d;
    int lat;
    apply_reset;

    // Fetch only, memory answers on the first busy cycle.
    add_fetch(32'h40);
    run_txn(1, 0, 32'h12345678, gd);

    // Store held for three busy cycles.
    add_data(1'b1, 32'h100, 32'hDEADBEEF);
    run_txn(3, 0, $urandom, gd);

    // mem_ready arrives exactly on the abort cycle.
    add_data(1'b0, 32'h104, 32'h0);
    run_txn(T, 0, 32'hA5A5A5A5, gd);

    // Both requesters held high.
    apply_reset;
    add_fetch(32'h80);
    add_data(1'b0, 32'h90, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_txn(2, 0, $urandom, gd);
`ifdef MEM_ARB_RR_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check_eq("contention_order", gd, exp_d);
      if (!d_pend) add_data(1'b0, 32'h90, 32'h0);
      if (!f_pend) add_fetch(32'h80);
    end

    // Memory never answers a fetch; a later load must still work.
    apply_reset;
    add_fetch(32'h44);
    run_txn(T + 2, 0, $urandom, gd);
    add_data(1'b0, 32'h48, 32'h0);
    run_txn(2, 0, 32'hCAFEF00D, gd);

    // Reset in the middle of a store: port drops at once, no ack.
    apply_reset;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h200;
    d_wdata   = 32'h55AA55AA;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mid_busy_mem_req", mem_req, 1);
    check_eq("mid_busy_mem_addr", mem_addr, 32'h200);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_eq("mid_rst_mem_req", mem_req, 0);
    check_eq("mid_rst_d_ack", d_ack, 0);
    check_eq("mid_rst_d_rdata", d_rdata, 0);
    check_eq("mid_rst_mem_addr", mem_addr, 0);
    d_req     = 1'b0;
    mem_ready = 1'b0;
    f_pend = 0; d_pend = 0; favour_fetch = 0; err_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    add_fetch(32'h300);
    run_txn(2, 0, 32'h0BADC0DE, gd);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      if (!f_pend && $urandom_range(0, 1) == 1) add_fetch($urandom);
      if (!d_pend && $urandom_range(0, 1) == 1)
        add_data(1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!f_pend && !d_pend) add_fetch($urandom);
      lat = $urandom_range(1, T + 2);
      run_txn(lat, $urandom_range(0, 3), $urandom, gd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
